// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing memory port A between two valid/ready requesters; one request in flight.
// Accept to response is 2+MEM_LAT cycles; ready is held low outside IDLE, so at most one accept per 3+MEM_LAT cycles.
module memory_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_t            state_q;
  logic              last_grant_q;
  logic              grant_q;
  logic              cmd_we_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_rdata_q;
  logic [DATA_W-1:0] rsp1_rdata_q;

  logic win;
  logic accept;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) begin
      win = ~last_grant_q;
    end else if (req1_valid) begin
      win = 1'b1;
    end
  end

  assign accept     = (state_q == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state_q == S_IDLE) && req0_valid && !win;
  assign req1_ready = (state_q == S_IDLE) && req1_valid && win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cmd_we_q     <= 1'b0;
      cnt_q        <= 2'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mem_addr_q   <= win ? req1_addr  : req0_addr;
            mem_wdata_q  <= win ? req1_wdata : req0_wdata;
            mem_we_q     <= win ? req1_we    : req0_we;
            cmd_we_q     <= win ? req1_we    : req0_we;
            grant_q      <= win;
            last_grant_q <= win;
            state_q      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_we_q <= 1'b0;
          cnt_q    <= LAT_M1;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= S_RESP;
            if (grant_q) begin
              rsp1_valid_q <= 1'b1;
              rsp1_rdata_q <= cmd_we_q ? '0 : mem_rdata;
            end else begin
              rsp0_valid_q <= 1'b1;
              rsp0_rdata_q <= cmd_we_q ? '0 : mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Two arbiters (MEM_LAT 1 and 3), each with a latency-accurate memory and a transaction-level reference model.
module tb_memory_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        r_vld [2][2];
  logic        r_we  [2][2];
  logic        r_rdy [2][2];
  logic [15:0] r_addr[2][2];
  logic [15:0] r_wdat[2][2];
  logic        s_vld [2][2];
  logic [15:0] s_dat [2][2];
  logic [15:0] m_addr[2];
  logic [15:0] m_wdat[2];
  logic [15:0] m_rdat[2];
  logic        m_we  [2];
  logic        m_busy[2];
  logic        m_gid [2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    return (16'(i) * 16'h0101) ^ 16'h5A00;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 1 : 3;

    memory_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r_vld[k][0]), .req0_we(r_we[k][0]), .req0_addr(r_addr[k][0]),
      .req0_wdata(r_wdat[k][0]), .req0_ready(r_rdy[k][0]),
      .req1_valid(r_vld[k][1]), .req1_we(r_we[k][1]), .req1_addr(r_addr[k][1]),
      .req1_wdata(r_wdat[k][1]), .req1_ready(r_rdy[k][1]),
      .rsp0_valid(s_vld[k][0]), .rsp0_rdata(s_dat[k][0]),
      .rsp1_valid(s_vld[k][1]), .rsp1_rdata(s_dat[k][1]),
      .mem_addr(m_addr[k]), .mem_wdata(m_wdat[k]), .mem_we(m_we[k]), .mem_rdata(m_rdat[k]),
      .busy(m_busy[k]), .grant_id(m_gid[k])
    );

    // Memory with a LAT-stage registered read; only address bits [3:0] select a word.
    logic [15:0] mem  [16];
    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      end else if (m_we[k]) begin
        mem[m_addr[k][3:0]] <= m_wdat[k];
      end
      pipe[0] <= mem[m_addr[k][3:0]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdat[k] = pipe[LAT-1];

    // Reference: each accept books the port for 3+LAT cycles and schedules one response.
    logic [15:0] ref_mem [16];
    initial begin
      int          cyc, free_at, pend_at, acc_at;
      bit          last, gid, pend, pwe, pid, w, idle, er;
      logic [15:0] pdat, paddr, pwdat;
      logic [15:0] held [2];
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          cyc = 0; free_at = 0; last = 1'b1; gid = 1'b0; pend = 1'b0;
          held[0] = '0; held[1] = '0;
          for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        end else begin
          idle = (cyc >= free_at);
          er   = pend && (cyc == pend_at);
          if (er) held[pid] = pdat;
          chk("rsp0_valid", s_vld[k][0], er && !pid);
          chk("rsp1_valid", s_vld[k][1], er && pid);
          chk("rsp0_rdata", s_dat[k][0], held[0]);
          chk("rsp1_rdata", s_dat[k][1], held[1]);
          chk("busy", m_busy[k], !idle);
          chk("grant_id", m_gid[k], gid);
          chk("mem_we", m_we[k], pend && (cyc == acc_at) && pwe);
          if (pend && cyc == acc_at) begin
            chk("mem_addr", m_addr[k], paddr);
            if (pwe) chk("mem_wdata", m_wdat[k], pwdat);
          end
          if (er) pend = 1'b0;
          w = (r_vld[k][0] && r_vld[k][1]) ? !last : r_vld[k][1];
          chk("req0_ready", r_rdy[k][0], idle && r_vld[k][0] && !w);
          chk("req1_ready", r_rdy[k][1], idle && r_vld[k][1] && w);
          if (idle && (r_vld[k][0] || r_vld[k][1])) begin
            pid   = w;
            pwe   = r_we[k][w];
            paddr = r_addr[k][w];
            pwdat = r_wdat[k][w];
            pdat  = pwe ? 16'h0000 : ref_mem[paddr[3:0]];
            if (pwe) ref_mem[paddr[3:0]] = pwdat;
            pend    = 1'b1;
            acc_at  = cyc + 1;
            pend_at = cyc + 2 + LAT;
            free_at = cyc + 3 + LAT;
            last    = w;
            gid     = w;
          end
          cyc++;
        end
      end
    end
  end

  task automatic drain(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input int k, input int n, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdat, output int lat, output logic [15:0] rd);
    int t_acc;
    r_vld[k][n] = 1'b1; r_we[k][n] = we; r_addr[k][n] = addr; r_wdat[k][n] = wdat;
    t_acc = -1; lat = -1; rd = 16'hDEAD;
    for (int c = 0; c < 60 && lat < 0; c++) begin
      @(negedge clk);
      if (t_acc < 0 && r_rdy[k][n]) t_acc = c;
      else if (t_acc >= 0 && s_vld[k][n]) begin
        lat = c - t_acc;
        rd  = s_dat[k][n];
      end
      if (lat < 0) begin
        @(posedge clk);
        #1;
        if (t_acc >= 0) r_vld[k][n] = 1'b0;
      end
    end
    r_vld[k][n] = 1'b0;
  endtask

  // req0 raised at once; req1 raised at once (d1<0) or d1 cycles after req0's accept.
  task automatic two_req(input int k, input int d1, input logic [15:0] a0, input logic [15:0] a1,
                         output int t0, output int t1, output int tr0);
    r_vld[k][0] = 1'b1; r_we[k][0] = 1'b0; r_addr[k][0] = a0;
    r_vld[k][1] = (d1 < 0); r_we[k][1] = 1'b0; r_addr[k][1] = a1;
    t0 = -1; t1 = -1; tr0 = -1;
    for (int c = 0; c < 40 && !(t0 >= 0 && t1 >= 0 && tr0 >= 0); c++) begin
      @(negedge clk);
      if (r_vld[k][0] && r_rdy[k][0]) t0 = c;
      if (r_vld[k][1] && r_rdy[k][1]) t1 = c;
      if (s_vld[k][0] && tr0 < 0) tr0 = c;
      @(posedge clk);
      #1;
      if (t0 >= 0) r_vld[k][0] = 1'b0;
      if (t1 >= 0) r_vld[k][1] = 1'b0;
      if (d1 >= 0 && t0 >= 0 && t1 < 0 && c == t0 + d1) r_vld[k][1] = 1'b1;
    end
    r_vld[k][0] = 1'b0;
    r_vld[k][1] = 1'b0;
  endtask

  task automatic rand_phase(input int k, input int ncyc);
    bit acc [2];
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) acc[n] = r_vld[k][n] && r_rdy[k][n];
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
        if (acc[n] && $urandom_range(3) == 0) continue;
        if (acc[n] || !r_vld[k][n] || $urandom_range(9) == 0) begin
          r_vld[k][n]  = ($urandom_range(2) != 0);
          r_we[k][n]   = ($urandom_range(1) == 1);
          r_addr[k][n] = ($urandom_range(7) == 0) ? 16'($urandom) : 16'($urandom_range(15));
          r_wdat[k][n] = 16'($urandom);
        end
      end
    end
    r_vld[k][0] = 1'b0;
    r_vld[k][1] = 1'b0;
  endtask

  initial begin
    int          lat, t0, t1, tr0, pulses;
    bit          got;
    logic [15:0] rd;
    int          ids [$];

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 2; n++) begin
        r_vld[k][n] = 1'b0; r_we[k][n] = 1'b0; r_addr[k][n] = '0; r_wdat[k][n] = '0;
      end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drain(2);

    two_req(0, -1, 16'h0000, 16'h0001, t0, t1, tr0);
    chk("tie_first_accept", t0, 0);
    chk("tie_second_accept", t1, 4);
    chk("tie_first_rsp", tr0, 3);
    drain(8);

    for (int k = 0; k < 2; k++) begin
      do_req(k, 0, 1'b1, 16'h0005, 16'h1234, lat, rd);
      chk("wr_latency", lat, 2 + ((k == 0) ? 1 : 3));
      chk("wr_rdata", rd, 16'h0000);
      drain(2);
      do_req(k, 0, 1'b0, 16'h0005, 16'h0000, lat, rd);
      chk("rd_latency", lat, 2 + ((k == 0) ? 1 : 3));
      chk("rd_rdata", rd, 16'h1234);
      drain(2);
    end

    two_req(0, 1, 16'h0005, 16'h0007, t0, t1, tr0);
    chk("late_req0_accept", t0, 0);
    chk("late_req1_accept", t1, 4);
    chk("late_req0_rsp", tr0, 3);
    drain(8);

    r_vld[0][0] = 1'b1; r_we[0][0] = 1'b0; r_addr[0][0] = 16'h0002;
    r_vld[0][1] = 1'b1; r_we[0][1] = 1'b0; r_addr[0][1] = 16'h0003;
    for (int c = 0; c < 100 && ids.size() < 6; c++) begin
      @(negedge clk);
      if (r_rdy[0][0]) ids.push_back(0);
      if (r_rdy[0][1]) ids.push_back(1);
      @(posedge clk);
      #1;
    end
    r_vld[0][0] = 1'b0;
    r_vld[0][1] = 1'b0;
    chk("fair_count", ids.size(), 6);
    for (int i = 0; i < ids.size(); i++) chk("fair_grant", ids[i], i % 2);
    drain(8);

    rand_phase(0, 800);
    drain(10);
    rand_phase(1, 800);
    drain(12);

    r_vld[0][0] = 1'b1; r_we[0][0] = 1'b1; r_addr[0][0] = 16'h0009; r_wdat[0][0] = 16'hBEEF;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = r_rdy[0][0];
      @(posedge clk);
      #1;
    end
    r_vld[0][0] = 1'b0;
    chk("rst_pre_mem_we", m_we[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_we", m_we[0], 1'b0);
    chk("rst_busy", m_busy[0], 1'b0);
    chk("rst_grant_id", m_gid[0], 1'b0);
    chk("rst_mem_addr", m_addr[0], 16'h0000);
    chk("rst_rsp0_valid", s_vld[0][0], 1'b0);
    chk("rst_rsp0_rdata", s_dat[0][0], 16'h0000);
    chk("rst_rsp1_rdata", s_dat[0][1], 16'h0000);
    chk("rst_dut1_rdata", s_dat[1][0], 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s_vld[0][0]) pulses++;
    end
    chk("rst_no_rsp", pulses, 0);

    rand_phase(0, 300);
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
